cnn_layer_accel_octo_input_router: RTL and testbench
====================================================

Name: cnn_layer_accel_octo_input_router

Overview:
- Upstream stage of the octo block.
- Accepts one word-serial input stream carrying packets. Each packet is a header word followed by payload words.
- Steers each payload word onto the shared datain bus and raises the matching pixel_datain_tag or seq_datain_tag.
- Throttles the stream with the octo's pixel_datain_rdy and seq_datain_rdy. Drops packets of unknown type and flags them.

Parameters:
- C_PIXEL_WIDTH, 18: width of the stream and datain words. Must be ≥ C_LEN_WIDTH + 2.
- C_LEN_WIDTH, 16: width of the header length field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_data  in  C_PIXEL_WIDTH  input stream word
- s_valid  in  1  s_data valid
- s_rdy  out  1  router accepts s_data this cycle
- datain  out  C_PIXEL_WIDTH  word to octo
- datain_valid  out  1  datain holds a pending word
- pixel_datain_tag  out  1  pending word is pixel data
- pixel_datain_rdy  in  1  octo accepts pixel word
- seq_datain_tag  out  1  pending word is sequencer data
- seq_datain_rdy  in  1  octo accepts sequencer word
- busy  out  1  packet in progress or output word pending
- pkt_done  out  1  one-cycle pulse when the last payload word of a packet is accepted by the octo
- err_type  out  1  sticky: a header with an unknown type was seen

Behaviour:
- Reset (async, active-high), all outputs 0:
  - s_rdy=0, datain=0, datain_valid=0, both tags=0, busy=0, pkt_done=0, err_type=0.
  - State = ST_HDR, remaining count = 0.
- Header word layout:
  - s_data[C_LEN_WIDTH+1:C_LEN_WIDTH] = type: 2'b00 sequencer, 2'b01 pixel, 2'b10/2'b11 invalid.
  - s_data[C_LEN_WIDTH-1:0] = LEN, the payload word count.
- Stream handshake: an input transfer occurs when s_valid & s_rdy are both high in the same cycle.
- Output handshake: an output transfer occurs when datain_valid & ((pixel_datain_tag & pixel_datain_rdy) | (seq_datain_tag & seq_datain_rdy)).
- Output register:
  - datain, datain_valid and the tags are all registered; the tag is stored together with its word.
  - A word is held stable until its output transfer.
  - Exactly one tag is high whenever datain_valid=1. Both tags are 0 when datain_valid=0.
- out_free = ~datain_valid | output transfer this cycle.
- State machine:
  - ST_HDR:
    - s_rdy=1 unconditionally; a header never occupies the output register.
    - On input transfer with LEN=0: stay in ST_HDR, no pkt_done.
    - type 00 → ST_SEQ. type 01 → ST_PIX. Remaining count loaded with LEN.
    - type 1x → ST_DROP, remaining = LEN, err_type set. If LEN=0, set err_type and stay in ST_HDR.
  - ST_SEQ / ST_PIX:
    - s_rdy = out_free.
    - Each input transfer loads the output register next cycle with datain=s_data, datain_valid=1 and the state's tag. Remaining decrements.
    - On the transfer that takes remaining from 1 to 0, go to ST_HDR. The last word may still be pending in the output register.
  - ST_DROP:
    - s_rdy=1. Words are consumed and discarded; remaining decrements.
    - Go to ST_HDR when remaining reaches 0.
- Latency: one cycle from input transfer to datain_valid.
- Throughput: one word per cycle while the selected rdy stays high (output reg loads in the same cycle it empties).
- A header that arrives while the previous packet's last word is still pending is accepted. A following word of a different type then waits on out_free, so the tag never changes while a word is pending.
- pkt_done: asserted the cycle after the output transfer of a word marked last-of-packet. The last-of-packet flag is stored alongside the word.
- busy = (state != ST_HDR) | datain_valid.
- Remaining counter is C_LEN_WIDTH bits. LEN = 2^C_LEN_WIDTH-1 must work with no wrap.
- A rdy input for the non-selected tag is ignored.
- err_type clears only on rst.
- rst asserted mid-packet: immediate return to the reset values; the pending word is discarded.

Test Plan:
- Header 0x00003 (seq, LEN=3), payloads 0x11,0x22,0x33, seq_datain_rdy=1 → datain shows 0x11,0x22,0x33 on consecutive cycles with seq_datain_tag=1, pixel tag 0. pkt_done pulses once; busy falls after the last word.
- Header 0x10004 (pixel, LEN=4), pixel_datain_rdy toggling 1,0,1,0 → each word held stable while rdy=0, s_rdy low during stalls. All 4 words delivered in order with pixel_datain_tag=1.
- Header 0x00000 followed by header 0x10001 with payload 0x3FFFF → no output and no pkt_done for the first header. One pixel word 0x3FFFF delivered.
- Header 0x20002 (invalid), payloads 0xAA,0xBB, then header 0x00001 with payload 0xCC → AA/BB never appear on datain and err_type=1 stays set. 0xCC delivered with seq tag.
- Seq packet LEN=1 (0x55) with seq_datain_rdy=0, immediately followed by pixel header LEN=1 (0x66) → pixel header accepted; 0x66 held off (s_rdy=0) until 0x55 is taken. 0x55 keeps seq tag, then 0x66 appears with pixel tag.
- rst pulsed during word 2 of a pixel LEN=5 packet → all outputs 0 asynchronously. After release, a new header 0x00001 is decoded correctly.

Source files
------------

// File: rtl/cnn_layer_accel_octo_input_router.sv
// Input router for the octo block: decodes packet headers and steers payload
// words onto the shared datain bus with a pixel or sequencer tag.
module cnn_layer_accel_octo_input_router #(
    parameter int C_PIXEL_WIDTH = 18,
    parameter int C_LEN_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [C_PIXEL_WIDTH-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_rdy,
    output logic [C_PIXEL_WIDTH-1:0] datain,
    output logic                     datain_valid,
    output logic                     pixel_datain_tag,
    input  logic                     pixel_datain_rdy,
    output logic                     seq_datain_tag,
    input  logic                     seq_datain_rdy,
    output logic                     busy,
    output logic                     pkt_done,
    output logic                     err_type
);

    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_SEQ  = 2'd1;
    localparam logic [1:0] ST_PIX  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]             state;
    logic [C_LEN_WIDTH-1:0] rem;
    logic                   last_q;

    logic [1:0]             hdr_type;
    logic [C_LEN_WIDTH-1:0] hdr_len;
    logic                   out_xfer;
    logic                   out_free;
    logic                   in_xfer;
    logic                   rem_last;

    assign hdr_type = s_data[C_LEN_WIDTH+1:C_LEN_WIDTH];
    assign hdr_len  = s_data[C_LEN_WIDTH-1:0];
    assign rem_last = (rem == C_LEN_WIDTH'(1));

    assign out_xfer = datain_valid &
                      ((pixel_datain_tag & pixel_datain_rdy) |
                       (seq_datain_tag & seq_datain_rdy));
    assign out_free = ~datain_valid | out_xfer;
    assign in_xfer  = s_valid & s_rdy;
    assign busy     = (state != ST_HDR) | datain_valid;

    // s_rdy is held low while reset is asserted so the stream never sees
    // an acceptance the core cannot act on.
    always_comb begin
        s_rdy = 1'b0;
        unique case (state)
            ST_HDR:  s_rdy = 1'b1;
            ST_SEQ:  s_rdy = out_free;
            ST_PIX:  s_rdy = out_free;
            ST_DROP: s_rdy = 1'b1;
            default: s_rdy = 1'b0;
        endcase
        s_rdy = s_rdy & ~rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_HDR;
            rem              <= '0;
            last_q           <= 1'b0;
            datain           <= '0;
            datain_valid     <= 1'b0;
            pixel_datain_tag <= 1'b0;
            seq_datain_tag   <= 1'b0;
            pkt_done         <= 1'b0;
            err_type         <= 1'b0;
        end else begin
            pkt_done <= out_xfer & last_q;

            if (out_xfer) begin
                datain_valid     <= 1'b0;
                pixel_datain_tag <= 1'b0;
                seq_datain_tag   <= 1'b0;
                last_q           <= 1'b0;
            end

            unique case (state)
                ST_HDR: begin
                    if (in_xfer) begin
                        if (hdr_type[1])
                            err_type <= 1'b1;
                        if (hdr_len != '0) begin
                            rem <= hdr_len;
                            unique case (1'b1)
                                hdr_type[1]: state <= ST_DROP;
                                hdr_type[0]: state <= ST_PIX;
                                default:     state <= ST_SEQ;
                            endcase
                        end
                    end
                end
                ST_SEQ, ST_PIX: begin
                    // in_xfer implies out_free, so this load wins over the clear above
                    if (in_xfer) begin
                        datain           <= s_data;
                        datain_valid     <= 1'b1;
                        pixel_datain_tag <= (state == ST_PIX);
                        seq_datain_tag   <= (state == ST_SEQ);
                        last_q           <= rem_last;
                        rem              <= rem - C_LEN_WIDTH'(1);
                        if (rem_last)
                            state <= ST_HDR;
                    end
                end
                ST_DROP: begin
                    if (in_xfer) begin
                        rem <= rem - C_LEN_WIDTH'(1);
                        if (rem_last)
                            state <= ST_HDR;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_octo_input_router.sv
// Scoreboard bench for the octo input router: stimulus pushes expected words,
// a negedge monitor pops and compares on every output transfer.
module tb_cnn_layer_accel_octo_input_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] s_data;
    logic        s_valid;
    logic        s_rdy;
    logic [17:0] datain;
    logic        datain_valid;
    logic        pixel_datain_tag;
    logic        pixel_datain_rdy;
    logic        seq_datain_tag;
    logic        seq_datain_rdy;
    logic        busy;
    logic        pkt_done;
    logic        err_type;

    typedef struct {
        logic [17:0] data;
        bit          pix;
        bit          last;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   done_cnt = 0;
    bit   exp_done = 0;
    bit   stall_chk = 0;
    bit   tog = 0;

    cnn_layer_accel_octo_input_router #(
        .C_PIXEL_WIDTH(18),
        .C_LEN_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_rdy(s_rdy),
        .datain(datain),
        .datain_valid(datain_valid),
        .pixel_datain_tag(pixel_datain_tag),
        .pixel_datain_rdy(pixel_datain_rdy),
        .seq_datain_tag(seq_datain_tag),
        .seq_datain_rdy(seq_datain_rdy),
        .busy(busy),
        .pkt_done(pkt_done),
        .err_type(err_type)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk)
        if (tog) #1 pixel_datain_rdy = ~pixel_datain_rdy;

    // Monitor: pops on each output transfer, checks tag and pkt_done timing.
    always @(negedge clk) begin
        bit   xfer;
        exp_t e;
        if (rst) begin
            exp_done = 0;
        end else begin
            xfer = datain_valid &
                   ((pixel_datain_tag & pixel_datain_rdy) |
                    (seq_datain_tag & seq_datain_rdy));
            if (exp_done || pkt_done)
                chk("pkt_done", 32'(pkt_done), 32'(exp_done));
            if (pkt_done)
                done_cnt++;
            exp_done = 0;
            if (datain_valid)
                chk("tag_onehot",
                    32'(pixel_datain_tag) + 32'(seq_datain_tag), 1);
            if (stall_chk && datain_valid && !xfer)
                chk("s_rdy_stall", 32'(s_rdy), 0);
            if (xfer) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_word: got 0x%0h expected none",
                             datain);
                end else begin
                    e = q.pop_front();
                    chk("datain", 32'(datain), 32'(e.data));
                    chk("pix_tag", 32'(pixel_datain_tag), 32'(e.pix));
                    chk("seq_tag", 32'(seq_datain_tag), 32'(!e.pix));
                    exp_done = e.last;
                end
            end
        end
    end

    task automatic send(input logic [17:0] w);
        bit ok;
        bit r;
        ok = 0;
        s_data  = w;
        s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            r = s_rdy;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ok)
            chk("send_timeout", 0, 1);
    endtask

    task automatic word(input bit pix, input logic [17:0] w, input bit last);
        exp_t e;
        e.data = w;
        e.pix  = pix;
        e.last = last;
        q.push_back(e);
        send(w);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok)
            chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_rdy"}, 32'(s_rdy), 0);
        chk({tag, "_datain"}, 32'(datain), 0);
        chk({tag, "_valid"}, 32'(datain_valid), 0);
        chk({tag, "_pix_tag"}, 32'(pixel_datain_tag), 0);
        chk({tag, "_seq_tag"}, 32'(seq_datain_tag), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_pkt_done"}, 32'(pkt_done), 0);
        chk({tag, "_err"}, 32'(err_type), 0);
    endtask

    initial begin
        rst = 1'b1;
        s_data = '0;
        s_valid = 1'b0;
        pixel_datain_rdy = 1'b0;
        seq_datain_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // seq LEN=3 at full rate
        seq_datain_rdy = 1'b1;
        send(18'h00003);
        word(0, 18'h11, 0);
        word(0, 18'h22, 0);
        word(0, 18'h33, 1);
        drain();
        chk("t1_busy", 32'(busy), 0);

        // pixel LEN=4 with toggling rdy
        pixel_datain_rdy = 1'b1;
        tog = 1;
        send(18'h10004);
        stall_chk = 1;
        word(1, 18'h101, 0);
        word(1, 18'h202, 0);
        word(1, 18'h303, 0);
        word(1, 18'h3FFFE, 1);
        stall_chk = 0;
        drain();
        tog = 0;
        #1 pixel_datain_rdy = 1'b1;

        // zero-length header then pixel LEN=1 at full width
        send(18'h00000);
        @(negedge clk);
        chk("t3_busy_len0", 32'(busy), 0);
        @(posedge clk);
        #1;
        send(18'h10001);
        word(1, 18'h3FFFF, 1);
        drain();

        // invalid type is dropped and flagged
        send(18'h20002);
        send(18'h000AA);
        send(18'h000BB);
        @(negedge clk);
        chk("t4_err_set", 32'(err_type), 1);
        chk("t4_no_output", 32'(datain_valid), 0);
        @(posedge clk);
        #1;
        send(18'h00001);
        word(0, 18'hCC, 1);
        drain();
        chk("t4_err_sticky", 32'(err_type), 1);

        // pixel header behind a stalled seq word
        seq_datain_rdy = 1'b0;
        send(18'h00001);
        word(0, 18'h55, 1);
        send(18'h10001);
        s_data  = 18'h66;
        s_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t5_held_off", 32'(s_rdy), 0);
            chk("t5_pending_seq", 32'(seq_datain_tag), 1);
            @(posedge clk);
            #1;
        end
        seq_datain_rdy = 1'b1;
        word(1, 18'h66, 1);
        drain();

        // async reset mid-packet
        send(18'h10005);
        word(1, 18'h0A1, 0);
        send(18'h0A2);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(18'h00001);
        word(0, 18'h77, 1);
        drain();

        chk("pkt_done_count", 32'(done_cnt), 7);
        chk("final_busy", 32'(busy), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
